// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan reader: active-low segment patterns
// and the decoder result type. Hex digit patterns are used only when SEG7_READER_HEX_EN is defined.
package seg7_pkg;

  // Segment bit order is {a,b,c,d,e,f,g}: bit 6 is segment a, bit 0 is segment g; 0 lights a segment.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       ok;
    logic       blank;
    logic [3:0] value;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Display bus tap (segments + anodes) and the recovered-digit readback signals.
interface seg7_scan_reader_if #(parameter int NDIG = 4);
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] digit;
  logic [NDIG-1:0]   blank;
  logic [NDIG-1:0]   err;
  logic              upd;

  modport master (output seg, output an, input digit, input blank, input err, input upd);
  modport slave  (input seg, input an, output digit, output blank, output err, output upd);
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-segment decoder.
// SEG7_READER_HEX_EN adds the A-F patterns as recognised values.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output seg7_dec_t  dec
);

  // Blank reports value F so a blank digit and a displayed F differ only in the blank bit.
  always_comb begin
    dec = '{ok: 1'b1, blank: 1'b0, value: 4'h0};
    case (pattern)
      SEG_0:     dec.value = 4'h0;
      SEG_1:     dec.value = 4'h1;
      SEG_2:     dec.value = 4'h2;
      SEG_3:     dec.value = 4'h3;
      SEG_4:     dec.value = 4'h4;
      SEG_5:     dec.value = 4'h5;
      SEG_6:     dec.value = 4'h6;
      SEG_7:     dec.value = 4'h7;
      SEG_8:     dec.value = 4'h8;
      SEG_9:     dec.value = 4'h9;
`ifdef SEG7_READER_HEX_EN
      SEG_A:     dec.value = 4'hA;
      SEG_B:     dec.value = 4'hB;
      SEG_C:     dec.value = 4'hC;
      SEG_D:     dec.value = 4'hD;
      SEG_E:     dec.value = 4'hE;
      SEG_F:     dec.value = 4'hF;
`else
`endif
      SEG_BLANK: begin
        dec.blank = 1'b1;
        dec.value = 4'hF;
      end
      default:   dec.ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers debounced BCD digits from a multiplexed active-low 7-segment bus.
// Optional hex recognition via SEG7_READER_HEX_EN (applied inside seg7_pattern_decode).
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_reader_if.slave bus
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

  logic [6:0]        cand_q [NDIG];
  logic [CW-1:0]     cnt_q  [NDIG];
  logic [4*NDIG-1:0] digit_q;
  logic [NDIG-1:0]   blank_q;
  logic [NDIG-1:0]   err_q;
  logic              upd_q;

  logic [IW-1:0] obs_idx;
  logic          observe;
  logic          seen;
  logic          multi;
  logic [CW-1:0] next_cnt;
  logic          commit;
  logic [3:0]    new_digit;
  logic          new_blank;
  logic          new_err;
  logic          changed;
  seg7_dec_t     dec;

  // Only one digit can be observed per cycle, so a single shared decoder suffices.
  seg7_pattern_decode u_decode (
    .pattern (bus.seg),
    .dec     (dec)
  );

  always_comb begin
    obs_idx = '0;
    seen    = 1'b0;
    multi   = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!bus.an[i]) begin
        if (seen) multi = 1'b1;
        seen    = 1'b1;
        obs_idx = IW'(i);
      end
    end
    observe = seen && !multi;
  end

  // Unrecognised patterns flag err but keep the digit's last good value.
  always_comb begin
    if (bus.seg == cand_q[obs_idx])
      next_cnt = (cnt_q[obs_idx] == CNT_MAX) ? CNT_MAX : cnt_q[obs_idx] + CW'(1);
    else
      next_cnt = CW'(1);
    commit    = observe && (next_cnt == CNT_MAX);
    new_digit = dec.ok ? dec.value : digit_q[4*obs_idx +: 4];
    new_blank = dec.ok && dec.blank;
    new_err   = !dec.ok;
    changed   = commit &&
                ({new_digit, new_blank, new_err} !=
                 {digit_q[4*obs_idx +: 4], blank_q[obs_idx], err_q[obs_idx]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        cand_q[i] <= SEG_BLANK;
        cnt_q[i]  <= '0;
      end
      digit_q <= '0;
      blank_q <= '1;
      err_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= changed;
      if (observe) begin
        cand_q[obs_idx] <= bus.seg;
        cnt_q[obs_idx]  <= next_cnt;
      end
      if (changed) begin
        digit_q[4*obs_idx +: 4] <= new_digit;
        blank_q[obs_idx]        <= new_blank;
        err_q[obs_idx]          <= new_err;
      end
    end
  end

  assign bus.digit = digit_q;
  assign bus.blank = blank_q;
  assign bus.err   = err_q;
  assign bus.upd   = upd_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scenarios plus a random
// run against a sliding-window reference model. Honours SEG7_READER_HEX_EN.
module tb_seg7_scan_reader;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;
`ifdef SEG7_READER_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  seg7_scan_reader_if #(.NDIG(NDIG)) bus ();

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: a digit commits when its last STABLE observations are identical.
  logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [6:0]        hist [NDIG][$];
  logic [4*NDIG-1:0] m_digit;
  logic [NDIG-1:0]   m_blank;
  logic [NDIG-1:0]   m_err;
  logic              m_upd;

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) hist[i].delete();
    m_digit = '0;
    m_blank = '1;
    m_err   = '0;
    m_upd   = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [NDIG-1:0] a);
    int n, d;
    bit same, known, blk;
    logic [3:0] v, nv;
    n = 0; d = 0; known = 0; blk = 0; v = 4'h0;
    m_upd = 1'b0;
    for (int i = 0; i < NDIG; i++) if (a[i] == 1'b0) begin n++; d = i; end
    if (n != 1) return;
    hist[d].push_back(s);
    if (hist[d].size() > STABLE) void'(hist[d].pop_front());
    if (hist[d].size() != STABLE) return;
    same = 1;
    for (int j = 0; j < hist[d].size(); j++) if (hist[d][j] != s) same = 0;
    if (!same) return;
    for (int k = 0; k < 16; k++)
      if (s == tbl[k] && (k < 10 || HEX)) begin known = 1; v = 4'(k); end
    if (s == 7'h7F) begin known = 1; blk = 1; v = 4'hF; end
    nv = known ? v : m_digit[4*d +: 4];
    if ({nv, blk, !known} != {m_digit[4*d +: 4], m_blank[d], m_err[d]}) begin
      m_digit[4*d +: 4] = nv;
      m_blank[d] = blk;
      m_err[d]   = !known;
      m_upd      = 1'b1;
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [NDIG-1:0] a);
    @(negedge clk);
    bus.seg = s;
    bus.an  = a;
    @(posedge clk);
    model_edge(s, a);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.an = '1;
    bus.seg = 7'h7F;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(7'h00, 4'b1111);
      vectors++;
      if ({bus.digit, bus.blank, bus.err, bus.upd} !== {16'h0000, 4'hF, 4'h0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset_state: got digit=%h blank=%b err=%b upd=%b, want 0000/1111/0000/0",
                 bus.digit, bus.blank, bus.err, bus.upd);
      end
    end
  endtask

  task automatic test_commit();
    for (int k = 0; k < 5; k++) begin
      step(7'b0010010, 4'b1110);
      vectors++;
      if (bus.upd !== (k == 3)) begin
        miscompares++;
        $display("[TB] FAIL commit_upd[%0d]: got %b, want %b", k, bus.upd, (k == 3));
      end
    end
    vectors++;
    if ({bus.digit[3:0], bus.blank[0], bus.err[0]} !== {4'd2, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL commit_value: got d=%h b=%b e=%b, want 2/0/0",
               bus.digit[3:0], bus.blank[0], bus.err[0]);
    end
  endtask

  task automatic test_glitch();
    logic [6:0] seq [8] = '{7'b0010010, 7'b0010010, 7'b0010010, 7'b0000000,
                            7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010};
    for (int k = 0; k < 8; k++) begin
      step(seq[k], 4'b1011);
      vectors++;
      if (bus.upd !== (k == 7)) begin
        miscompares++;
        $display("[TB] FAIL glitch_upd[%0d]: got %b, want %b", k, bus.upd, (k == 7));
      end
      if (k == 6) begin
        vectors++;
        if ({bus.digit[11:8], bus.blank[2]} !== {4'd0, 1'b1}) begin
          miscompares++;
          $display("[TB] FAIL glitch_hold: got d=%h b=%b, want 0/1", bus.digit[11:8], bus.blank[2]);
        end
      end
    end
    vectors++;
    if ({bus.digit[11:8], bus.blank[2]} !== {4'd2, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL glitch_commit: got d=%h b=%b, want 2/0", bus.digit[11:8], bus.blank[2]);
    end
  endtask

  task automatic test_multi_anode();
    logic [4*NDIG-1:0] d0;
    for (int k = 0; k < 3; k++) step(7'b1001111, 4'b0111);
    d0 = bus.digit;
    for (int k = 0; k < 10; k++) begin
      step((k < 5) ? 7'b1001111 : 7'b0000000, (k < 5) ? 4'b1100 : 4'b0011);
      vectors++;
      if ({bus.digit, bus.upd} !== {d0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL multi_anode[%0d]: got digit=%h upd=%b, want %h/0", k, bus.digit, bus.upd, d0);
      end
    end
    step(7'b1001111, 4'b0111);
    vectors++;
    if ({bus.digit[15:12], bus.blank[3], bus.upd} !== {4'd1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL resume_count: got d=%h b=%b upd=%b, want 1/0/1",
               bus.digit[15:12], bus.blank[3], bus.upd);
    end
  endtask

  task automatic test_hex();
    for (int k = 0; k < 4; k++) step(7'b0001000, 4'b1101);
    vectors++;
    if ({bus.digit[7:4], bus.err[1], bus.blank[1], bus.upd} !==
        (HEX ? {4'hA, 1'b0, 1'b0, 1'b1} : {4'h0, 1'b1, 1'b0, 1'b1})) begin
      miscompares++;
      $display("[TB] FAIL hex_A: got d=%h e=%b b=%b upd=%b, hex_en=%0d",
               bus.digit[7:4], bus.err[1], bus.blank[1], bus.upd, HEX);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] pats [4] = '{7'b0000100, 7'b0000110, 7'b0100100, 7'b0100000};
    for (int d = 0; d < NDIG; d++)
      for (int k = 0; k < 3; k++) step(pats[d], ~(4'b0001 << d));
    for (int d = 0; d < NDIG; d++) begin
      step(pats[d], ~(4'b0001 << d));
      vectors++;
      if (bus.upd !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_upd[%0d]: got %b, want 1", d, bus.upd);
      end
    end
    step(7'h00, 4'b1111);
    vectors++;
    if ({bus.digit, bus.blank, bus.err, bus.upd} !== {16'h6539, 4'h0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL b2b_final: got digit=%h blank=%b err=%b upd=%b, want 6539/0000/0000/0",
               bus.digit, bus.blank, bus.err, bus.upd);
    end
  endtask

  task automatic test_scan();
    logic [6:0] pats [4] = '{7'b0000100, 7'b1001111, 7'b0001111, 7'b1111111};
    int pulses;
    do_reset();
    pulses = 0;
    for (int sc = 0; sc < 2; sc++)
      for (int d = 0; d < NDIG; d++)
        for (int k = 0; k < 2; k++) begin
          step(pats[d], ~(4'b0001 << d));
          if (bus.upd === 1'b1) pulses++;
        end
    vectors++;
    if ({bus.digit, bus.blank, bus.err} !== {16'hF719, 4'b1000, 4'h0} || pulses != 4) begin
      miscompares++;
      $display("[TB] FAIL scan_commit: got digit=%h blank=%b err=%b pulses=%0d, want F719/1000/0000/4",
               bus.digit, bus.blank, bus.err, pulses);
    end
    for (int d = 0; d < 3; d++) step(7'b0000000, ~(4'b0001 << d));
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.digit, bus.blank, bus.err, bus.upd} !== {16'h0000, 4'hF, 4'h0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got digit=%h blank=%b err=%b upd=%b, want 0000/1111/0000/0",
               bus.digit, bus.blank, bus.err, bus.upd);
    end
    bus.an = '1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(7'b0000000, 4'b1110);
    vectors++;
    if ({bus.digit[3:0], bus.upd} !== {4'd8, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL post_reset_count: got d=%h upd=%b, want 8/1", bus.digit[3:0], bus.upd);
    end
  endtask

  task automatic test_random();
    logic [6:0] last [NDIG];
    logic [6:0] s;
    logic [NDIG-1:0] a;
    int d;
    for (int i = 0; i < NDIG; i++) last[i] = tbl[$urandom_range(0, 9)];
    for (int n = 0; n < 600; n++) begin
      d = $urandom_range(0, NDIG - 1);
      case ($urandom_range(0, 9))
        0:       a = 4'($urandom);
        1:       a = 4'b1111;
        default: a = ~(4'b0001 << d);
      endcase
      case ($urandom_range(0, 11))
        0:       last[d] = tbl[$urandom_range(0, 15)];
        1:       last[d] = 7'h7F;
        2:       last[d] = 7'($urandom);
        default: ;
      endcase
      s = ($urandom_range(0, 15) == 0) ? 7'($urandom) : last[d];
      step(s, a);
      vectors++;
      if ({bus.digit, bus.blank, bus.err, bus.upd} !== {m_digit, m_blank, m_err, m_upd}) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: got digit=%h blank=%b err=%b upd=%b, want %h/%b/%b/%b",
                 n, bus.digit, bus.blank, bus.err, bus.upd, m_digit, m_blank, m_err, m_upd);
      end
    end
  endtask

  initial begin
    bus.seg = 7'h7F;
    bus.an  = '1;
    model_reset();
    test_reset();
    test_commit();
    test_glitch();
    test_multi_anode();
    test_hex();
    test_back_to_back();
    test_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Recovers the BCD digits shown on a multiplexed, active-low 7-segment display bus: it watches the segment lines and the anode strobes, debounces each digit's pattern, and decodes it back to a 4-bit value. It is the read side of the team's BCD-to-segment decoder. It sits between a scanned display driver (or an external display tap) and logic that needs the displayed value, such as checkers, loopback tests, or a readback register.

## Interface
Parameters:
- NDIG, 4: number of multiplexed digits (≥1).
- STABLE, 4: consecutive identical observations required before a digit commits (≥1).

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- seg, input, 7: segments {ca,cb,cc,cd,ce,cf,cg}, active-low. Driven synchronously to clk.
- an, input, NDIG: anode enables, active-low. Digit i is selected when only an[i] is 0.
- digit, output, 4*NDIG: committed value of digit i, in bits [4i+3:4i].
- blank, output, NDIG: digit i shows the all-off pattern 7'b1111111.
- err, output, NDIG: the last committed pattern for digit i was not recognised.
- upd, output, 1: one-cycle pulse when any digit, blank or err bit changes.

## Operation
- Observation: a cycle in which exactly one bit of an is 0. Cycles with zero or several anodes active are ignored, and no state changes in them.
- Each digit holds its own candidate pattern (7 bits) and a counter of width $clog2(STABLE+1).
  - If the observed seg equals the candidate, the counter increments and saturates at STABLE.
  - Otherwise the candidate is replaced by seg and the counter is set to 1.
- Commit: when the counter for digit i reaches STABLE on this observation, the pattern is decoded.
  - If the decoded {digit, blank, err} differs from what is held, the new value is written and upd pulses.
  - Re-commits of an identical value produce no pulse.
- Decode, combinational. Patterns and values:
  - 0000001 = 0, 1001111 = 1, 0010010 = 2, 0000110 = 3, 1001100 = 4
  - 0100100 = 5, 0100000 = 6, 0001111 = 7, 0000000 = 8, 0000100 = 9
  - 1111111 gives blank=1, digit=4'hF, err=0.
  - Any other pattern gives err=1, blank=0, and the digit value holds its previous value.
- Several digits can be pending at once, but only one can commit per cycle, because only one anode is active.

## Timing
- Reset values:
  - digit: all 0
  - blank: all 1
  - err: 0
  - upd: 0
  - counters: 0
  - candidates: 7'h7F
- Commit latency: if a pattern is first sampled at edge t, digit, blank, err and upd change at edge t+STABLE-1. With STABLE=1, they change at the same edge that samples the pattern.
- upd is high for exactly one cycle per commit. Back-to-back commits on consecutive cycles give upd high on consecutive cycles.
- An anode switching away does not clear a digit's counter. Observations of a digit need not be contiguous in time.
- A glitch of one observation on a digit restarts that digit's count. The committed value is unaffected.
- rst_n asserted mid-count returns everything to the reset values immediately. Counting restarts from 0 after release.

## Configuration
- SEG7_READER_HEX_EN defined: these patterns decode with err=0, blank=0:
  - 0001000 = 4'hA, 1100000 = 4'hB, 0110001 = 4'hC
  - 1000010 = 4'hD, 0110000 = 4'hE, 0111000 = 4'hF
- SEG7_READER_HEX_EN undefined: those six patterns give err=1.
- With the macro, blank and a displayed F both report digit=4'hF. They are distinguished only by the blank bit.

## Structure
- Package seg7_pkg contains:
  - localparams for the ten decimal patterns, the six hex patterns and SEG_BLANK = 7'h7F
  - the segment bit-order convention {a..g}
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern in; {ok, blank, value[3:0]} out. The macro is applied only inside this sub-module.
- The top level holds the per-digit candidate registers, counters and output registers, and the anode one-hot check.

## Test plan
- Reset, then no activity: digit=0, blank=all 1s, err=0, upd=0.
- STABLE=4, an=4'b1110, seg=0010010 for 4 cycles: digit[3:0]=2 and blank[0]=0 at the 4th edge, with one upd pulse.
- Same pattern for 3 cycles, then 1 cycle of 0000000, then 4 cycles of 0010010: no commit of 8. The commit of 2 occurs only after the final 4.
- an=4'b1100 (two anodes) for 10 cycles with seg=1001111: no state change, no upd.
- seg=0001000 held for 4 observations on digit 1: with the macro, digit[7:4]=4'hA and err[1]=0. Without it, err[1]=1 and digit[7:4] is unchanged.
- Scan digits 0–3 round-robin, 2 cycles each, showing 9, 1, 7, blank: all four commit after the second full scan. Reasserting rst_n mid-scan restores the reset values.
